// File: rtl/lcd_pixel_prefetch.sv
// Pixel prefetch FIFO between the AXI read DMA and the LCD timing generator.
// Requests fixed-length bursts while space is reserved, serves one pixel per
// request with one cycle of latency, and flushes at every vsync falling edge.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame budget and a full burst worth of free space
// REQ   | burst_req held high until the DMA acknowledges
// XFER  | accepting beats of the current burst into the FIFO
// DRAIN | accepting and discarding beats of a burst that a flush orphaned
module lcd_pixel_prefetch #(
    parameter int DEPTH        = 512,
    parameter int AW           = 9,
    parameter int BURST_LEN    = 64,
    parameter int FRAME_PIXELS = 384000
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          burst_req,
    input  logic          burst_ack,
    output logic          frame_start,
    input  logic          s_valid,
    input  logic [23:0]   s_data,
    output logic          s_ready,
    input  logic          lcd_request,
    input  logic          lcd_framesync,
    output logic [23:0]   lcd_data,
    output logic [AW:0]   fifo_level,
    output logic          underflow
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

    localparam logic [AW:0] LVL_MAX    = (AW+1)'(DEPTH - BURST_LEN);
    localparam logic [AW:0] BURST_CNT  = (AW+1)'(BURST_LEN);
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [19:0] BURST_PIX  = 20'(BURST_LEN);
    localparam logic [19:0] FRAME_LOAD = 20'(FRAME_PIXELS);

    logic [23:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] beat_cnt;
    logic [19:0] remaining;
    logic        fs_q;
    logic        flush;
    logic        req_flushed;
    logic        empty;
    logic        beat;
    logic        last_beat;
    logic        push;
    logic        pop;
    state_t      state;
    state_t      state_next;

    assign flush      = fs_q & ~lcd_framesync;
    assign empty      = (wptr == rptr);
    assign fifo_level = wptr - rptr;
    assign beat       = s_valid & s_ready;
    assign last_beat  = beat && (beat_cnt == ONE);
    // A beat landing in the flush cycle belongs to the old frame.
    assign push       = beat && (state == XFER) && !flush;
    // Flush wins over a concurrent request, which then sees an empty FIFO.
    assign pop        = lcd_request && !empty && !flush;

    // Pixel storage; write port only, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= s_data;
        end
    end

    // Registered read port: popped pixel, zero on an empty request, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_data <= '0;
        end else if (pop) begin
            lcd_data <= mem[rptr[AW-1:0]];
        end else if (lcd_request) begin
            lcd_data <= '0;
        end
    end

    // FIFO pointers, sticky underflow flag and vsync edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            underflow   <= 1'b0;
            fs_q        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            fs_q        <= lcd_framesync;
            frame_start <= flush;
            if (flush) begin
                wptr      <= '0;
                rptr      <= '0;
                underflow <= 1'b0;
            end else begin
                if (push) begin
                    wptr <= wptr + ONE;
                end
                if (pop) begin
                    rptr <= rptr + ONE;
                end
                if (lcd_request && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    // Burst state register plus beat counter, frame budget and flush-in-REQ memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            remaining   <= FRAME_LOAD;
            req_flushed <= 1'b0;
        end else begin
            state <= state_next;
            if (state == REQ && burst_ack) begin
                beat_cnt <= BURST_CNT;
            end else if (beat) begin
                beat_cnt <= beat_cnt - ONE;
            end
            // A burst orphaned by a flush does not count against the new frame.
            if (flush) begin
                remaining <= FRAME_LOAD;
            end else if (state == REQ && burst_ack && !req_flushed) begin
                remaining <= (remaining > BURST_PIX) ? remaining - BURST_PIX : '0;
            end
            if (state == REQ) begin
                if (burst_ack) begin
                    req_flushed <= 1'b0;
                end else if (flush) begin
                    req_flushed <= 1'b1;
                end
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        burst_req  = 1'b0;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && remaining != '0 && fifo_level <= LVL_MAX) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                burst_req = 1'b1;
                if (burst_ack) begin
                    state_next = (flush || req_flushed) ? DRAIN : XFER;
                end
            end
            XFER: begin
                s_ready = 1'b1;
                if (last_beat) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_pixel_prefetch.sv
// Bench for lcd_pixel_prefetch: a queue-based pixel model checked every cycle,
// directed frame-sync scenarios with randomized beat data and gaps, and a
// second instance with a small frame budget served by an automatic DMA.
module tb_lcd_pixel_prefetch;

    localparam int DEPTH = 512;
    localparam int BURST = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        burst_req, burst_ack, frame_start;
    logic        s_valid, s_ready;
    logic [23:0] s_data;
    logic        lcd_request, lcd_framesync;
    logic [23:0] lcd_data;
    logic [9:0]  fifo_level;
    logic        underflow;

    logic        burst_req_b, burst_ack_b, frame_start_b;
    logic        s_valid_b, s_ready_b;
    logic [23:0] s_data_b;
    logic        lcd_request_b, lcd_framesync_b;
    logic [23:0] lcd_data_b;
    logic [9:0]  fifo_level_b;
    logic        underflow_b;

    int n_chk  = 0;
    int n_pass = 0;
    int acks_b = 0;

    // model state
    logic [23:0] q[$];
    logic [23:0] m_data = '0;
    bit          m_under = 0, m_fstart = 0, fs_prev = 1;
    bit          req_out = 0, m_req_flushed = 0, m_discard = 0;
    int          m_beats = 0;

    always #5 clk = ~clk;

    lcd_pixel_prefetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .burst_req(burst_req), .burst_ack(burst_ack), .frame_start(frame_start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .lcd_request(lcd_request), .lcd_framesync(lcd_framesync),
        .lcd_data(lcd_data), .fifo_level(fifo_level), .underflow(underflow)
    );

    lcd_pixel_prefetch #(.FRAME_PIXELS(256)) u_small (
        .clk(clk), .rst_n(rst_n),
        .burst_req(burst_req_b), .burst_ack(burst_ack_b), .frame_start(frame_start_b),
        .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
        .lcd_request(lcd_request_b), .lcd_framesync(lcd_framesync_b),
        .lcd_data(lcd_data_b), .fifo_level(fifo_level_b), .underflow(underflow_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock: apply spec rules to the driven inputs, then compare.
    task automatic cycle();
        bit fl, hs, held, acked;
        fl    = fs_prev && !lcd_framesync;
        hs    = s_valid && (m_beats > 0);
        held  = req_out && !burst_ack;
        acked = burst_ack;
        if (fl) begin
            q.delete();
            m_under = 0;
            if (lcd_request) m_data = '0;
        end else if (lcd_request) begin
            if (q.size() > 0) m_data = q.pop_front();
            else begin
                m_data  = '0;
                m_under = 1;
            end
        end
        if (fl && m_beats > 0) m_discard = 1;
        if (hs) begin
            if (!m_discard) begin
                if (q.size() >= DEPTH) check("overflow", q.size(), DEPTH - 1);
                else q.push_back(s_data);
            end
            m_beats--;
            if (m_beats == 0) m_discard = 0;
        end
        if (fl && req_out && !burst_ack) m_req_flushed = 1;
        if (burst_ack) begin
            m_beats       = BURST;
            m_discard     = m_req_flushed || fl;
            m_req_flushed = 0;
            req_out       = 0;
        end
        m_fstart = fl;
        fs_prev  = lcd_framesync;
        @(posedge clk); #1;
        check("lcd_data", lcd_data, m_data);
        check("level", fifo_level, q.size());
        check("underflow", underflow, m_under);
        check("s_ready", s_ready, m_beats > 0);
        check("frame_start", frame_start, m_fstart);
        if (held)  check("req_hold", burst_req, 1);
        if (acked) check("req_drop", burst_req, 0);
        if (burst_req) req_out = 1;
    endtask

    task automatic vsync_pulse();
        s_valid = 0;
        lcd_request = 0;
        lcd_framesync = 0;
        cycle();
        lcd_framesync = 1;
        cycle();
    endtask

    // One DMA burst. pop_mode: 0 none, 1 request mirrors s_valid from beat
    // pop_from on (level must then stay at hold_lvl), 2 random requests.
    task automatic do_burst(input int ack_delay, input bit flush_pre_ack, input int flush_at,
                            input int base, input bit gaps, input int pop_mode,
                            input int pop_from, input int hold_lvl);
        int n = 0;
        int sent = 0;
        bit v;
        bit fl_done = 0;
        while (!burst_req && n < 200) begin
            cycle();
            n++;
        end
        check("req_seen", burst_req, 1);
        if (!burst_req) return;
        if (flush_pre_ack) vsync_pulse();
        repeat (ack_delay) cycle();
        burst_ack = 1;
        cycle();
        burst_ack = 0;
        while (sent < BURST) begin
            if (sent == flush_at && !fl_done) begin
                fl_done = 1;
                vsync_pulse();
            end
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_valid = v;
            s_data  = (base >= 0) ? 24'(base + sent) : 24'($urandom);
            case (pop_mode)
                1:       lcd_request = v && (sent >= pop_from);
                2:       lcd_request = ($urandom_range(0, 1) == 1);
                default: lcd_request = 0;
            endcase
            cycle();
            if (pop_mode == 1 && v && sent >= pop_from) check("lvl_const", fifo_level, hold_lvl);
            if (v) sent++;
        end
        s_valid = 0;
        lcd_request = 0;
    endtask

    // Automatic DMA for the small-budget instance.
    always begin
        @(posedge clk); #1;
        if (burst_req_b) begin
            repeat (2) begin @(posedge clk); #1; end
            burst_ack_b = 1;
            @(posedge clk); #1;
            burst_ack_b = 0;
            acks_b++;
            for (int i = 0; i < BURST; i++) begin
                s_valid_b = 1;
                s_data_b  = 24'(i);
                @(posedge clk); #1;
            end
            s_valid_b = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        burst_ack = 0; s_valid = 0; s_data = '0; lcd_request = 0; lcd_framesync = 1;
        burst_ack_b = 0; s_valid_b = 0; s_data_b = '0; lcd_request_b = 0; lcd_framesync_b = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_burst_req", burst_req, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underflow", underflow, 0);
        rst_n = 1;

        // fill: first burst is a counting pattern, then random bursts to full
        do_burst(0, 0, -1, 1, 0, 0, 0, 0);
        for (int b = 1; b < 8; b++) do_burst($urandom_range(0, 3), 0, -1, -1, 1, 0, 0, 0);
        check("full_level", fifo_level, 512);
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("no_req_full", burst_req, 0);
        end
        lcd_request = 1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("rd_seq", lcd_data, k + 1);
        end
        lcd_request = 0;

        // flush, empty-read underflow, second flush clears it
        lcd_framesync = 0;
        cycle();
        check("fs_pulse", frame_start, 1);
        check("fs_level", fifo_level, 0);
        lcd_framesync = 1;
        cycle();
        check("fs_once", frame_start, 0);
        lcd_request = 1;
        cycle();
        lcd_request = 0;
        check("uf_data", lcd_data, 0);
        check("uf_set", underflow, 1);
        repeat (5) cycle();
        check("uf_sticky", underflow, 1);
        lcd_framesync = 0;
        cycle();
        check("fs2_pulse", frame_start, 1);
        check("uf_clear", underflow, 0);
        lcd_framesync = 1;
        cycle();

        // request orphaned by the flush above drains entirely
        do_burst(2, 0, -1, -1, 1, 0, 0, 0);
        check("drain_a_lvl", fifo_level, 0);
        // flush after 20 of 64 beats
        do_burst(1, 0, 20, -1, 0, 0, 0, 0);
        check("drain_b_lvl", fifo_level, 0);
        // flush while request pending, ack 5 cycles later
        do_burst(5, 1, -1, -1, 0, 0, 0, 0);
        check("drain_c_lvl", fifo_level, 0);

        // advance pointers to 448, empty the FIFO, then stream at level 32
        for (int b = 0; b < 7; b++) do_burst($urandom_range(0, 2), 0, -1, -1, 1, 0, 0, 0);
        check("pre_wrap_lvl", fifo_level, 448);
        lcd_request = 1;
        repeat (448) cycle();
        lcd_request = 0;
        check("emptied", fifo_level, 0);
        do_burst(1, 0, -1, -1, 1, 1, 32, 32);
        do_burst(0, 0, -1, -1, 1, 1, 0, 32);
        do_burst(3, 0, -1, -1, 1, 1, 0, 32);
        check("wrap_lvl", fifo_level, 32);

        // random traffic with reads, then a random mid-burst flush
        for (int b = 0; b < 4; b++) do_burst($urandom_range(0, 4), 0, -1, -1, 1, 2, 0, 0);
        do_burst($urandom_range(0, 4), 0, $urandom_range(1, 63), -1, 1, 2, 0, 0);
        repeat (10) cycle();

        // small frame budget: four bursts, then silence until vsync
        check("b_acks_frame1", acks_b, 4);
        check("b_no_req", burst_req_b, 0);
        check("b_level1", fifo_level_b, 256);
        lcd_framesync_b = 0;
        @(posedge clk); #1;
        check("b_frame_start", frame_start_b, 1);
        lcd_framesync_b = 1;
        repeat (600) @(posedge clk);
        #1;
        check("b_acks_frame2", acks_b, 8);
        check("b_no_req2", burst_req_b, 0);
        check("b_level2", fifo_level_b, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_prefetch.md
Name: lcd_pixel_prefetch

Overview:
- Single-clock pixel prefetch FIFO between the AXI read DMA and the LCD timing generator.
- Issues fixed-length burst requests to the DMA, accepts returned 24-bit RGB beats, and serves one pixel per cycle on the timing generator's data request.
- Flushes and restarts at every vertical sync so each frame begins clean, even after an underflow.

Parameters:
- DEPTH, 512, FIFO entries; power of two, ≥ 2*BURST_LEN.
- AW, 9, log2(DEPTH).
- BURST_LEN, 64, pixels per DMA burst; power of two, ≤ DEPTH/2.
- FRAME_PIXELS, 384000, visible pixels per frame (800*480); upper bound on pixels requested per frame.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, asynchronous assert, active-low
- burst_req  out  1  request one BURST_LEN burst from DMA
- burst_ack  in  1  DMA accepted request (1-cycle pulse)
- frame_start  out  1  1-cycle pulse; DMA reloads frame base address
- s_valid  in  1  DMA beat valid
- s_data  in  24  DMA beat RGB888
- s_ready  out  1  block accepts beat
- lcd_request  in  1  pixel request from timing generator (one cycle ahead of display)
- lcd_framesync  in  1  vsync, active-low during sync
- lcd_data  out  24  pixel to timing generator
- fifo_level  out  AW+1  current occupancy
- underflow  out  1  sticky: request seen while empty this frame

Behaviour:
- Reset values: burst_req=0, frame_start=0, s_ready=0, lcd_data=0, fifo_level=0, underflow=0; pointers=0; state=IDLE; remaining=FRAME_PIXELS.
- Reset releases into IDLE and fetches normally; no frame_start is issued until the first vsync falling edge.
- FIFO: read/write pointers are AW+1 bits wide.
  - empty when pointers are equal.
  - fifo_level = wptr - rptr, modulo 2^(AW+1).
  - Memory is inferred RAM with a registered read.
- Read side:
  - lcd_request=1 and not empty: pop; lcd_data = popped pixel on the next cycle (latency 1).
  - lcd_request=1 and empty: no pop; lcd_data=0 on the next cycle; underflow is set.
  - lcd_request=0: lcd_data holds its value.
- Simultaneous push and pop in one cycle: fifo_level unchanged, both pointers advance.
- Frame sync:
  - Edge detector is a registered copy of lcd_framesync, reset value 1.
  - A falling edge (1→0) starts flush: frame_start pulses next cycle; rptr=wptr=0; underflow cleared; remaining reloaded to FRAME_PIXELS.
  - Flush and the simultaneous lcd_request: flush wins; the request is treated as empty but underflow is not set.
- Burst FSM states: IDLE, REQ, XFER, DRAIN.
  - IDLE → REQ when remaining ≥ 1 and free space (DEPTH - fifo_level) ≥ BURST_LEN. burst_req=1 in REQ.
  - REQ → XFER on burst_ack. remaining -= BURST_LEN, saturating at 0. Beat counter loads BURST_LEN.
  - XFER: s_ready=1. Each s_valid&s_ready pushes and decrements the beat counter. Last beat → IDLE.
  - Overflow is impossible because space was reserved at request time. A push when full is a design error; the bench asserts it never happens.
  - Flush while in REQ: burst_req stays high until burst_ack (no withdrawal), then → DRAIN.
  - Flush while in XFER: → DRAIN keeping the remaining beat count.
  - DRAIN: s_ready=1; beats are counted and discarded, never pushed. At count 0 → IDLE.
  - Flush in IDLE: stay IDLE; refetch begins the next cycle.
  - A second flush while in DRAIN: stay in DRAIN.
- Remaining counter: 20 bits. Once it reaches 0, no further requests are issued until the next flush.

Test Plan:
- Reset, DMA returns 64 beats 0x000001..0x000040 one per cycle after ack → burst_req reasserts until level≥449, never overflows. With lcd_request held 10 cycles, lcd_data = 0x000001..0x00000A, each one cycle after its request.
- Empty FIFO, single lcd_request → lcd_data=0 next cycle, underflow=1 and stays 1. A vsync falling edge → frame_start pulse, underflow=0, fifo_level=0.
- Vsync falls after 20 of 64 beats → FSM DRAIN, s_ready=1. The next 44 beats are discarded (level stays 0 through them), then a new burst_req follows.
- Vsync falls while burst_req is high before ack → burst_req is held; ack delayed 5 cycles → DRAIN consumes all 64 beats, none pushed.
- Simultaneous push and pop for 100 cycles at level 32 → fifo_level constant 32, data order preserved across pointer wrap past 511.
- FRAME_PIXELS=256 override → exactly 4 burst_acks, then no burst_req until the next vsync edge.
